// File: rtl/dtree_pkg.sv
// Shared types and helpers for the decision-tree feature front end.
package dtree_pkg;

   typedef enum logic [1:0] {LOAD, DRAIN, SETTLE, HOLD} state_t;

   localparam int unsigned FEAT_W_DEF  = 8;
   localparam int unsigned CLASS_W_DEF = 5;

   // Bit offset of feature slot 'slot' inside the flat feature bus.
   function automatic int unsigned slot_lsb(input int unsigned slot, input int unsigned feat_w);
      return slot * feat_w;
   endfunction

endpackage

// File: rtl/dtree_feat_regfile.sv
// Write-indexed bank of feature registers presented as one flat bus.
module dtree_feat_regfile
   import dtree_pkg::*;
#(
   parameter int unsigned NUM_FEAT = 7,
   parameter int unsigned FEAT_W   = FEAT_W_DEF,
   parameter int unsigned IDX_W    = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       we,
   input  logic [IDX_W-1:0]           widx,
   input  logic [FEAT_W-1:0]          wdata,
   output logic [NUM_FEAT*FEAT_W-1:0] bus
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_FEAT; i++) begin
            if (we && (widx == IDX_W'(i))) begin
               bus[slot_lsb(i, FEAT_W) +: FEAT_W] <= wdata;
            end
         end
      end
   end

endmodule

// File: rtl/dtree_feature_frontend.sv
// Byte-serial to parallel feature assembler that holds the tree inputs,
// samples the class after a settle window and offers it on a result port.
module dtree_feature_frontend
   import dtree_pkg::*;
#(
   parameter int unsigned NUM_FEAT      = 7,
   parameter int unsigned FEAT_W        = FEAT_W_DEF,
   parameter int unsigned CLASS_W       = CLASS_W_DEF,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [FEAT_W-1:0]          s_data,
   input  logic                       s_last,
   output logic [NUM_FEAT*FEAT_W-1:0] feat_bus,
   input  logic [CLASS_W-1:0]         cls_in,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [CLASS_W-1:0]         m_class,
   output logic                       frame_err,
   output logic [15:0]                frame_cnt
);

   localparam int unsigned IDX_W  = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned FCNT_W = 16;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                s_ready_d, m_valid_d, frame_err_d;
   logic [CLASS_W-1:0]  m_class_d;
   logic [FCNT_W-1:0]   frame_cnt_d;
   logic                xfer;
   logic                wr_en;

   assign xfer = s_valid && s_ready;

   dtree_feat_regfile #(
      .NUM_FEAT (NUM_FEAT),
      .FEAT_W   (FEAT_W),
      .IDX_W    (IDX_W)
   ) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en),
      .widx  (idx_q),
      .wdata (s_data),
      .bus   (feat_bus)
   );

   // Next-state and registered-output decode
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      m_valid_d   = m_valid;
      m_class_d   = m_class;
      frame_cnt_d = frame_cnt;
      frame_err_d = 1'b0;
      wr_en       = 1'b0;
      case (state_q)
         LOAD: begin
            if (xfer) begin
               wr_en = 1'b1;
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  if (s_last) begin
                     state_d = SETTLE;
                     cnt_d   = CNT_W'(SETTLE_CYCLES);
                  end else begin
                     state_d = DRAIN;
                  end
               end else if (s_last) begin
                  idx_d       = '0;
                  frame_err_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         DRAIN: begin
            if (xfer && s_last) begin
               idx_d       = '0;
               frame_err_d = 1'b1;
               state_d     = LOAD;
            end
         end
         SETTLE: begin
            cnt_d = cnt_q - CNT_W'(1);
            // Tree output is only trusted once the settle window has elapsed
            if (cnt_q == CNT_W'(1)) begin
               m_class_d   = cls_in;
               m_valid_d   = 1'b1;
               frame_cnt_d = frame_cnt + FCNT_W'(1);
               state_d     = HOLD;
            end
         end
         HOLD: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               state_d   = LOAD;
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase
      s_ready_d = (state_d == LOAD) || (state_d == DRAIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= LOAD;
         idx_q     <= '0;
         cnt_q     <= '0;
         s_ready   <= 1'b0;
         m_valid   <= 1'b0;
         m_class   <= '0;
         frame_err <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         s_ready   <= s_ready_d;
         m_valid   <= m_valid_d;
         m_class   <= m_class_d;
         frame_err <= frame_err_d;
         frame_cnt <= frame_cnt_d;
      end
   end

endmodule

// File: doc/dtree_feature_frontend.md
Name: dtree_feature_frontend

Overview:
- Input-side counterpart of the generated combinational decision-tree classifiers. Those trees take a parallel bundle of 8-bit features and return a small class code.
- This block receives a byte-serial feature stream over a valid/ready interface and assembles it into the parallel feature bus.
- It holds the bus stable while the tree output settles, then captures the class code and offers it on a valid/ready result port.
- It sits between the sensor/ADC sequencer and any dtree instance.

Parameters:
- NUM_FEAT, 7, number of features per frame (bytes per frame).
- FEAT_W, 8, feature width in bits.
- CLASS_W, 5, width of the tree's class code.
- SETTLE_CYCLES, 2, cycles the feature bus is held before the class is sampled (1..15).

Ports:
- clk, input, 1, single clock.
- rst_n, input, 1, asynchronous active-low reset.
- s_valid, input, 1, feature byte valid.
- s_ready, output, 1, block can accept a byte.
- s_data, input, FEAT_W, feature byte; the first byte of a frame is feature 0.
- s_last, input, 1, marks the final byte of a frame.
- feat_bus, output, NUM_FEAT*FEAT_W, feature i occupies bits [i*FEAT_W +: FEAT_W]; drives the tree inputs.
- cls_in, input, CLASS_W, class code returned by the tree.
- m_valid, output, 1, result valid.
- m_ready, input, 1, downstream accepts the result.
- m_class, output, CLASS_W, captured class code.
- frame_err, output, 1, one-cycle pulse when a malformed frame is dropped.
- frame_cnt, output, 16, count of classified frames; wraps modulo 2^16.

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD, idx=0, feat_bus=0, m_valid=0, m_class=0, frame_err=0, frame_cnt=0, settle counter=0.
  - s_ready=0 while rst_n is low, 1 in the first cycle after release.
  - Reset mid-frame discards all partial data.
- A transfer is s_valid && s_ready at a rising edge.
- s_ready=1 only in LOAD and DRAIN.
- States:
  - LOAD:
    - Each accepted byte is written to feature slot idx, and idx increments.
    - If the byte at idx=NUM_FEAT-1 has s_last=1: go to SETTLE, settle counter=SETTLE_CYCLES, idx=0.
    - If s_last=1 at idx<NUM_FEAT-1: frame too short. Pulse frame_err next cycle, idx=0, stay in LOAD; already-written slots keep stale values.
    - If the byte at idx=NUM_FEAT-1 has s_last=0: frame too long. Store the byte, go to DRAIN.
  - DRAIN:
    - Accept and discard bytes until one with s_last=1.
    - Then pulse frame_err, idx=0, return to LOAD.
  - SETTLE:
    - feat_bus is frozen; the counter decrements each cycle.
    - When the counter reaches 1, sample cls_in into m_class, set m_valid=1, increment frame_cnt, and go to HOLD.
    - Latency: last byte accepted at edge T, m_valid high after edge T+SETTLE_CYCLES.
  - HOLD:
    - m_valid=1; m_class and feat_bus are stable.
    - On m_ready=1: m_valid=0 next cycle, go to LOAD, s_ready=1 in that same next cycle.
    - m_ready=1 one cycle before m_valid rises has no effect.
- Back-to-back timing:
  - No overlap; the next frame's first byte is accepted no earlier than the cycle after the result handshake.
  - Minimum frame period is NUM_FEAT + SETTLE_CYCLES + 1 cycles.
- Output timing:
  - feat_bus updates only on LOAD writes, so slots change progressively during load.
  - The tree's output is ignored outside SETTLE.
  - m_class is registered and never combinational from cls_in.
- Widths:
  - idx is $clog2(NUM_FEAT) bits.
  - frame_cnt wraps 0xFFFF -> 0x0000 with no flag.

Decomposition:
- Shared package dtree_pkg holds:
  - state enum {LOAD, DRAIN, SETTLE, HOLD};
  - default FEAT_W/CLASS_W constants;
  - the feature-slot index function.
- Natural sub-module: dtree_feat_regfile, a NUM_FEAT-entry write-indexed register bank with a flat output bus and an async reset.
- The FSM, settle counter and result register stay in the top.

Test Plan:
- Nominal frame:
  - Stimulus: send 7 bytes 0x10..0x16 with s_last on the 7th, SETTLE_CYCLES=2, cls_in tied to 19, m_ready=1.
  - Required: feat_bus=0x16151413121110; m_valid is high exactly 2 cycles after the last accept; m_class=19; frame_cnt=1.
- Backpressure:
  - Stimulus: hold m_ready=0 for 10 cycles after m_valid, drive s_valid continuously.
  - Required: s_ready=0 and feat_bus and m_class stable throughout; after m_ready=1, m_valid drops and the next byte is accepted the following cycle.
- Short frame:
  - Stimulus: send s_last on the 4th byte.
  - Required: frame_err pulses once; no m_valid; frame_cnt unchanged; the next 7-byte frame classifies normally.
- Long frame:
  - Stimulus: send 9 bytes with s_last on the 9th.
  - Required: bytes 8-9 are discarded; frame_err pulses once after the 9th byte; feat_bus slot 6 holds byte 7.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 after 3 bytes.
  - Required: all outputs clear asynchronously; after release a full frame loads from slot 0.
- Wrap:
  - Stimulus: preload frame_cnt to 0xFFFF via 65535 frames (or force), then one more frame.
  - Required: frame_cnt reads 0x0000.
